// File: rtl/uu_acmac_cp_ba_bitmap_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : uu_acmac_cp_ba_bitmap_gen_if
// Purpose  : Bundles the request, sta_ba_info read-port and result signals
//            of the CP BlockAck bitmap generator.
// Modports : slave  - the generator (takes req/memory data, drives results)
//            master - the requester / memory side
// Signals  : cp_bag_en, cp_bag_in_req, cp_bag_in_sta_offset[14:0],
//            cp_bag_in_ssn[11:0], cp_bag_in_sta_ba_data[31:0] (to generator)
//            cp_bag_out_busy, cp_bag_out_sta_ba_en, cp_bag_out_sta_ba_addr,
//            cp_bag_out_bitmap[63:0], cp_bag_out_done, cp_bag_out_res[31:0],
//            cp_bag_out_basic_data[15:0], cp_bag_out_basic_val (from gen.)
// Revision : 1.0 - initial release
// ============================================================================
interface uu_acmac_cp_ba_bitmap_gen_if;
    logic        cp_bag_en;
    logic        cp_bag_in_req;
    logic [14:0] cp_bag_in_sta_offset;
    logic [11:0] cp_bag_in_ssn;
    logic        cp_bag_out_busy;
    logic        cp_bag_out_sta_ba_en;
    logic [14:0] cp_bag_out_sta_ba_addr;
    logic [31:0] cp_bag_in_sta_ba_data;
    logic [63:0] cp_bag_out_bitmap;
    logic        cp_bag_out_done;
    logic [31:0] cp_bag_out_res;
    logic [15:0] cp_bag_out_basic_data;
    logic        cp_bag_out_basic_val;

    modport slave (
        input  cp_bag_en, cp_bag_in_req, cp_bag_in_sta_offset, cp_bag_in_ssn,
               cp_bag_in_sta_ba_data,
        output cp_bag_out_busy, cp_bag_out_sta_ba_en, cp_bag_out_sta_ba_addr,
               cp_bag_out_bitmap, cp_bag_out_done, cp_bag_out_res,
               cp_bag_out_basic_data, cp_bag_out_basic_val
    );

    modport master (
        output cp_bag_en, cp_bag_in_req, cp_bag_in_sta_offset, cp_bag_in_ssn,
               cp_bag_in_sta_ba_data,
        input  cp_bag_out_busy, cp_bag_out_sta_ba_en, cp_bag_out_sta_ba_addr,
               cp_bag_out_bitmap, cp_bag_out_done, cp_bag_out_res,
               cp_bag_out_basic_data, cp_bag_out_basic_val
    );
endinterface
`default_nettype wire

// File: rtl/uu_acmac_cp_ba_bitmap_gen.sv
`default_nettype none
// ============================================================================
// Module   : uu_acmac_cp_ba_bitmap_gen
// Purpose  : Builds the 64-bit compressed BlockAck bitmap of one BA session
//            from the receive scoreboard held in sta_ba_info memory.
//            Fixed latency: done 71 cycles after req (6 on a bad header).
// Ports    : clk   - clock
//            rst_n - synchronous, ACTIVE-HIGH reset (historical name)
//            bag   - uu_acmac_cp_ba_bitmap_gen_if.slave (request, memory
//                    read port, bitmap/result, basic-bitmap beats)
// Options  : BA_BASIC_BITMAP_EN - when defined, also streams the 64 16-bit
//            fragment bitmaps (one beat per BMP data cycle) for Basic BA.
// Revision : 1.0 - initial release
// ============================================================================
module uu_acmac_cp_ba_bitmap_gen (
    input  logic                          clk,
    input  logic                          rst_n,
    uu_acmac_cp_ba_bitmap_gen_if.slave    bag
);
    localparam logic [31:0] UU_SUCCESS   = 32'd0;
    localparam logic [31:0] UU_FAILURE   = 32'd1;
    localparam logic [14:0] OFS_BUFWS    = 15'd33;
    localparam logic [14:0] OFS_WINSTART = 15'd66;
    localparam logic [14:0] OFS_WIN      = 15'd67;
    localparam logic [15:0] MAX_WINSIZE  = 16'd64;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_CHK  = 3'd2,
        S_BMP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        clear_w;

    logic [14:0] offset_q;
    logic [11:0] ssn_q;
    logic [1:0]  hcnt_q;
    logic [5:0]  bufws_q;
    logic [11:0] winstart_q;
    logic [11:0] winend_q;
    logic [15:0] winsize_q;
    logic [6:0]  j_q;
    logic        pv_q;       // a BMP read is returning data this cycle
    logic        pin_q;      // that read was in-window
    logic        phalf_q;    // 1: entry is in [15:0] (odd idx)
    logic [5:0]  pj_q;       // bitmap bit the returning data belongs to
    logic [63:0] bitmap_q;
    logic [31:0] res_q;

    logic        rd_en_w;
    logic [14:0] rd_addr_w;
    logic [11:0] sn_w, d_w, span_w;
    logic        inwin_w;
    logic [5:0]  idx_w;
    logic [6:0]  idx_p1_w;
    logic [14:0] bmp_addr_w;
    logic [15:0] entry_w;
    logic        fail_w;

    // Disable behaves exactly like reset.
    assign clear_w = rst_n | ~bag.cp_bag_en;

    // Window arithmetic is all modulo 4096, so windows crossing 4095->0
    // need no special handling.
    assign sn_w     = ssn_q + {6'd0, j_q[5:0]};
    assign d_w      = sn_w - winstart_q;
    assign span_w   = winend_q - winstart_q;
    assign inwin_w  = (d_w <= span_w);
    assign idx_w    = bufws_q + d_w[5:0];
    assign idx_p1_w = {1'b0, idx_w} + 7'd1;
    // Entries are packed two per word starting at offset+1; out-of-window
    // positions still issue a (discarded) read of offset+1.
    assign bmp_addr_w = offset_q + 15'd1 + (inwin_w ? {9'd0, idx_p1_w[6:1]} : 15'd0);

    assign entry_w = phalf_q ? bag.cp_bag_in_sta_ba_data[15:0]
                             : bag.cp_bag_in_sta_ba_data[31:16];

    assign fail_w = (winsize_q == 16'd0) || (winsize_q > MAX_WINSIZE) ||
                    ({4'd0, span_w} != (winsize_q - 16'd1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear_w) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_en_w   = 1'b0;
        rd_addr_w = 15'd0;
        case (state_q)
            S_IDLE: begin
                if (bag.cp_bag_in_req) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                // Three address cycles, then one more cycle to land the
                // last header word.
                if (hcnt_q == 2'd3) begin
                    state_d = S_CHK;
                end else begin
                    rd_en_w = 1'b1;
                    case (hcnt_q)
                        2'd0:    rd_addr_w = offset_q + OFS_BUFWS;
                        2'd1:    rd_addr_w = offset_q + OFS_WINSTART;
                        default: rd_addr_w = offset_q + OFS_WIN;
                    endcase
                end
            end
            S_CHK: begin
                state_d = fail_w ? S_DONE : S_BMP;
            end
            S_BMP: begin
                // j==64 is the drain cycle for the data of j==63.
                if (j_q[6]) begin
                    state_d = S_DONE;
                end else begin
                    rd_en_w   = 1'b1;
                    rd_addr_w = bmp_addr_w;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear_w) begin
            offset_q   <= 15'd0;
            ssn_q      <= 12'd0;
            hcnt_q     <= 2'd0;
            bufws_q    <= 6'd0;
            winstart_q <= 12'd0;
            winend_q   <= 12'd0;
            winsize_q  <= 16'd0;
            j_q        <= 7'd0;
            pv_q       <= 1'b0;
            pin_q      <= 1'b0;
            phalf_q    <= 1'b0;
            pj_q       <= 6'd0;
            bitmap_q   <= 64'd0;
            res_q      <= UU_FAILURE;
        end else begin
            pv_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bag.cp_bag_in_req) begin
                        offset_q <= bag.cp_bag_in_sta_offset;
                        ssn_q    <= bag.cp_bag_in_ssn;
                        bitmap_q <= 64'd0;
                        hcnt_q   <= 2'd0;
                        j_q      <= 7'd0;
                    end
                end
                S_HDR: begin
                    hcnt_q <= hcnt_q + 2'd1;
                    // Data lags its address by one cycle.
                    case (hcnt_q)
                        2'd1: bufws_q    <= bag.cp_bag_in_sta_ba_data[21:16];
                        2'd2: winstart_q <= bag.cp_bag_in_sta_ba_data[27:16];
                        2'd3: begin
                            winsize_q <= bag.cp_bag_in_sta_ba_data[31:16];
                            winend_q  <= bag.cp_bag_in_sta_ba_data[11:0];
                        end
                        default: ;
                    endcase
                end
                S_CHK: begin
                    if (fail_w) begin
                        res_q <= UU_FAILURE;
                    end
                end
                S_BMP: begin
                    if (!j_q[6]) begin
                        j_q     <= j_q + 7'd1;
                        pv_q    <= 1'b1;
                        pin_q   <= inwin_w;
                        phalf_q <= idx_w[0];
                        pj_q    <= j_q[5:0];
                    end else begin
                        res_q <= UU_SUCCESS;
                    end
                    if (pv_q) begin
                        bitmap_q[pj_q] <= pin_q & (entry_w != 16'd0);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bag.cp_bag_out_busy        = (state_q != S_IDLE);
    assign bag.cp_bag_out_done        = (state_q == S_DONE);
    assign bag.cp_bag_out_sta_ba_en   = rd_en_w;
    assign bag.cp_bag_out_sta_ba_addr = rd_addr_w;
    assign bag.cp_bag_out_bitmap      = bitmap_q;
    assign bag.cp_bag_out_res         = res_q;

`ifdef BA_BASIC_BITMAP_EN
    assign bag.cp_bag_out_basic_val  = pv_q;
    assign bag.cp_bag_out_basic_data = (pv_q && pin_q) ? entry_w : 16'd0;
`else
    assign bag.cp_bag_out_basic_val  = 1'b0;
    assign bag.cp_bag_out_basic_data = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uu_acmac_cp_ba_bitmap_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_uu_acmac_cp_ba_bitmap_gen
// Purpose  : Self-checking bench for uu_acmac_cp_ba_bitmap_gen with a
//            sta_ba_info memory model and an expected-result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uu_acmac_cp_ba_bitmap_gen;
    localparam logic [31:0] UU_SUCCESS = 32'd0;
    localparam logic [31:0] UU_FAILURE = 32'd1;
    localparam logic [14:0] NOEN       = 15'h7FFF;
    localparam logic [14:0] CFG_A = 15'h100;
    localparam logic [14:0] CFG_B = 15'h200;
    localparam logic [14:0] CFG_C = 15'h300;
    localparam logic [14:0] CFG_D = 15'h400;
    localparam logic [14:0] CFG_E = 15'h500;
    localparam logic [14:0] CFG_F = 15'h600;
    localparam logic [14:0] CFG_H = 15'h700;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uu_acmac_cp_ba_bitmap_gen_if bif ();

    uu_acmac_cp_ba_bitmap_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bag   (bif)
    );

    logic [31:0] mem [0:32767];

    always @(posedge clk) begin
        if (bif.cp_bag_out_sta_ba_en)
            bif.cp_bag_in_sta_ba_data <= mem[bif.cp_bag_out_sta_ba_addr];
    end

    typedef struct {
        logic [63:0] bm;
        logic [31:0] res;
        int          cyc;
        int          ens;
    } exp_t;

    exp_t        sb [$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          o_cyc, o_ens, bad_total;
    logic [63:0] o_bm;
    logic [31:0] o_res;
    logic [14:0] o_addr [0:80];

    task automatic set_hdr(input logic [14:0] off, input logic [9:0] bufws,
                           input logic [15:0] ws, input logic [15:0] wsize,
                           input logic [15:0] we);
        logic [14:0] a;
        a = off + 15'd33; mem[a][25:16] = bufws; mem[a][31:26] = 6'h2A;
        a = off + 15'd66; mem[a][31:16] = ws;    mem[a][15:0]  = 16'h5A5A;
        a = off + 15'd67; mem[a] = {wsize, we};
    endtask

    task automatic set_entry(input logic [14:0] off, input int idx, input logic [15:0] v);
        logic [14:0] a;
        a = off + 15'd1 + 15'((idx + 1) >> 1);
        if (idx % 2 == 1) mem[a][15:0] = v;
        else              mem[a][31:16] = v;
    endtask

    // Caller is at a negedge. hold = extra cycles req stays high before
    // the cycle it is expected to be accepted in.
    task automatic run_txn(input logic [14:0] off, input logic [11:0] ssn, input int hold);
        bif.cp_bag_in_sta_offset = off;
        bif.cp_bag_in_ssn        = ssn;
        bif.cp_bag_in_req        = 1'b1;
        repeat (hold + 1) @(posedge clk);
        #1 bif.cp_bag_in_req = 1'b0;
        o_cyc = -1; o_ens = 0; o_bm = '0; o_res = '0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k <= 80) o_addr[k] = bif.cp_bag_out_sta_ba_en ? bif.cp_bag_out_sta_ba_addr : NOEN;
            if (bif.cp_bag_out_sta_ba_en) o_ens++;
            if (bif.cp_bag_out_basic_val !== 1'b0 || bif.cp_bag_out_basic_data !== 16'd0) bad_total++;
            if (bif.cp_bag_out_done) begin
                o_cyc = k; o_bm = bif.cp_bag_out_bitmap; o_res = bif.cp_bag_out_res;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (bif.cp_bag_out_busy !== 1'b0) $display("FAIL rst busy: got %b want 0", bif.cp_bag_out_busy); else pass_cnt++;
        total_cnt++; if (bif.cp_bag_out_sta_ba_en !== 1'b0) $display("FAIL rst en: got %b want 0", bif.cp_bag_out_sta_ba_en); else pass_cnt++;
        total_cnt++; if (bif.cp_bag_out_sta_ba_addr !== 15'd0) $display("FAIL rst addr: got %h want 0", bif.cp_bag_out_sta_ba_addr); else pass_cnt++;
        total_cnt++; if (bif.cp_bag_out_bitmap !== 64'd0) $display("FAIL rst bitmap: got %h want 0", bif.cp_bag_out_bitmap); else pass_cnt++;
        total_cnt++; if (bif.cp_bag_out_done !== 1'b0) $display("FAIL rst done: got %b want 0", bif.cp_bag_out_done); else pass_cnt++;
        total_cnt++; if (bif.cp_bag_out_res !== UU_FAILURE) $display("FAIL rst res: got %h want %h", bif.cp_bag_out_res, UU_FAILURE); else pass_cnt++;
        total_cnt++; if (bif.cp_bag_out_basic_val !== 1'b0 || bif.cp_bag_out_basic_data !== 16'd0)
            $display("FAIL rst basic: got %b/%h want 0/0", bif.cp_bag_out_basic_val, bif.cp_bag_out_basic_data); else pass_cnt++;
        rst_n = 1'b0;
    endtask

    task automatic test_windows();
        logic [14:0] offs [8];
        logic [11:0] ssns [8];
        logic [63:0] bms  [8];
        exp_t        e;
        offs = '{CFG_A, CFG_B, CFG_B, CFG_C, CFG_C, CFG_C, CFG_H, CFG_H};
        ssns = '{12'd100, 12'd4090, 12'd4094, 12'd200, 12'd130, 12'd99, 12'd5, 12'd4};
        bms  = '{64'h5, 64'h40, 64'h4, 64'h0, 64'h3_FFFF_FFFF,
                 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h2};
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{bm: bms[i], res: UU_SUCCESS, cyc: 71, ens: 67});
            @(negedge clk);
            run_txn(offs[i], ssns[i], 0);
            e = sb.pop_front();
            total_cnt++; if (o_cyc !== e.cyc) $display("FAIL win%0d done_cycle: got %0d want %0d", i, o_cyc, e.cyc); else pass_cnt++;
            total_cnt++; if (o_bm !== e.bm) $display("FAIL win%0d bitmap: got %h want %h", i, o_bm, e.bm); else pass_cnt++;
            total_cnt++; if (o_res !== e.res) $display("FAIL win%0d res: got %h want %h", i, o_res, e.res); else pass_cnt++;
            total_cnt++; if (o_ens !== e.ens) $display("FAIL win%0d read_count: got %0d want %0d", i, o_ens, e.ens); else pass_cnt++;
            total_cnt++; if (o_addr[1] !== offs[i] + 15'd33) $display("FAIL win%0d hdr_addr: got %h want %h", i, o_addr[1], offs[i] + 15'd33); else pass_cnt++;
            if (i == 0) begin
                total_cnt++; if (o_addr[2] !== CFG_A + 15'd66 || o_addr[3] !== CFG_A + 15'd67 || o_addr[4] !== NOEN)
                    $display("FAIL win0 hdr_seq: got %h %h %h want %h %h %h", o_addr[2], o_addr[3], o_addr[4], CFG_A + 15'd66, CFG_A + 15'd67, NOEN); else pass_cnt++;
                total_cnt++; if (o_addr[6] !== CFG_A + 15'd6 || o_addr[7] !== CFG_A + 15'd7)
                    $display("FAIL win0 bmp_addr: got %h %h want %h %h", o_addr[6], o_addr[7], CFG_A + 15'd6, CFG_A + 15'd7); else pass_cnt++;
            end
            if (i == 3) begin
                total_cnt++; if (o_addr[6] !== CFG_C + 15'd1 || o_addr[69] !== CFG_C + 15'd1)
                    $display("FAIL win3 oow_addr: got %h %h want %h", o_addr[6], o_addr[69], CFG_C + 15'd1); else pass_cnt++;
            end
            @(negedge clk);
            total_cnt++; if (bif.cp_bag_out_bitmap !== e.bm || bif.cp_bag_out_busy !== 1'b0 || bif.cp_bag_out_done !== 1'b0)
                $display("FAIL win%0d hold: got bm=%h busy=%b done=%b want bm=%h busy=0 done=0", i,
                         bif.cp_bag_out_bitmap, bif.cp_bag_out_busy, bif.cp_bag_out_done, e.bm); else pass_cnt++;
        end
        total_cnt++; if (bad_total !== 0) $display("FAIL basic_off: got %0d active beats want 0", bad_total); else pass_cnt++;
    endtask

    task automatic test_fail();
        logic [14:0] offs [3];
        exp_t        e;
        offs = '{CFG_D, CFG_E, CFG_F};
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{bm: 64'd0, res: UU_FAILURE, cyc: 6, ens: 3});
            @(negedge clk);
            run_txn(offs[i], 12'd100, 0);
            e = sb.pop_front();
            total_cnt++; if (o_cyc !== e.cyc) $display("FAIL fail%0d done_cycle: got %0d want %0d", i, o_cyc, e.cyc); else pass_cnt++;
            total_cnt++; if (o_bm !== e.bm) $display("FAIL fail%0d bitmap: got %h want %h", i, o_bm, e.bm); else pass_cnt++;
            total_cnt++; if (o_res !== e.res) $display("FAIL fail%0d res: got %h want %h", i, o_res, e.res); else pass_cnt++;
            total_cnt++; if (o_ens !== e.ens) $display("FAIL fail%0d read_count: got %0d want %0d", i, o_ens, e.ens); else pass_cnt++;
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int   dn;
        // Enable dropped in cycle 30.
        @(negedge clk);
        bif.cp_bag_in_sta_offset = CFG_A; bif.cp_bag_in_ssn = 12'd100; bif.cp_bag_in_req = 1'b1;
        @(posedge clk); #1 bif.cp_bag_in_req = 1'b0;
        for (int k = 1; k <= 30; k++) @(negedge clk);
        bif.cp_bag_en = 1'b0;
        @(negedge clk);
        total_cnt++; if (bif.cp_bag_out_busy !== 1'b0 || bif.cp_bag_out_sta_ba_en !== 1'b0 || bif.cp_bag_out_done !== 1'b0)
            $display("FAIL en_drop state: got busy=%b en=%b done=%b want 0 0 0", bif.cp_bag_out_busy, bif.cp_bag_out_sta_ba_en, bif.cp_bag_out_done); else pass_cnt++;
        bif.cp_bag_en = 1'b1;
        dn = 0;
        repeat (80) begin @(negedge clk); if (bif.cp_bag_out_done) dn++; end
        total_cnt++; if (dn !== 0) $display("FAIL en_drop no_done: got %0d dones want 0", dn); else pass_cnt++;
        // Fresh request after the abort.
        sb.push_back('{bm: 64'h5, res: UU_SUCCESS, cyc: 71, ens: 67});
        @(negedge clk);
        run_txn(CFG_A, 12'd100, 0);
        e = sb.pop_front();
        total_cnt++; if (o_cyc !== e.cyc) $display("FAIL after_drop done_cycle: got %0d want %0d", o_cyc, e.cyc); else pass_cnt++;
        total_cnt++; if (o_bm !== e.bm || o_res !== e.res) $display("FAIL after_drop result: got %h/%h want %h/%h", o_bm, o_res, e.bm, e.res); else pass_cnt++;
        // Reset asserted mid-operation (cycle 20).
        @(negedge clk);
        bif.cp_bag_in_sta_offset = CFG_C; bif.cp_bag_in_ssn = 12'd130; bif.cp_bag_in_req = 1'b1;
        @(posedge clk); #1 bif.cp_bag_in_req = 1'b0;
        for (int k = 1; k <= 20; k++) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (bif.cp_bag_out_busy !== 1'b0 || bif.cp_bag_out_sta_ba_en !== 1'b0 || bif.cp_bag_out_sta_ba_addr !== 15'd0)
            $display("FAIL midrst ctl: got busy=%b en=%b addr=%h want 0 0 0", bif.cp_bag_out_busy, bif.cp_bag_out_sta_ba_en, bif.cp_bag_out_sta_ba_addr); else pass_cnt++;
        total_cnt++; if (bif.cp_bag_out_res !== UU_FAILURE || bif.cp_bag_out_bitmap !== 64'd0)
            $display("FAIL midrst result: got res=%h bm=%h want %h 0", bif.cp_bag_out_res, bif.cp_bag_out_bitmap, UU_FAILURE); else pass_cnt++;
        rst_n = 1'b0;
        dn = 0;
        repeat (80) begin @(negedge clk); if (bif.cp_bag_out_done) dn++; end
        total_cnt++; if (dn !== 0) $display("FAIL midrst no_done: got %0d dones want 0", dn); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sb.push_back('{bm: 64'h5, res: UU_SUCCESS, cyc: 71, ens: 67});
        sb.push_back('{bm: 64'h40, res: UU_SUCCESS, cyc: 71, ens: 67});
        @(negedge clk);
        run_txn(CFG_A, 12'd100, 0);
        e = sb.pop_front();
        total_cnt++; if (o_cyc !== e.cyc || o_bm !== e.bm) $display("FAIL b2b first: got cyc=%0d bm=%h want cyc=%0d bm=%h", o_cyc, o_bm, e.cyc, e.bm); else pass_cnt++;
        // req raised in the DONE cycle and held into the following cycle.
        run_txn(CFG_B, 12'd4090, 1);
        e = sb.pop_front();
        total_cnt++; if (o_cyc !== e.cyc) $display("FAIL b2b done_cycle: got %0d want %0d", o_cyc, e.cyc); else pass_cnt++;
        total_cnt++; if (o_bm !== e.bm || o_res !== e.res) $display("FAIL b2b result: got %h/%h want %h/%h", o_bm, o_res, e.bm, e.res); else pass_cnt++;
    endtask

    initial begin
        bad_total = 0;
        rst_n = 1'b1;
        bif.cp_bag_en = 1'b1;
        bif.cp_bag_in_req = 1'b0;
        bif.cp_bag_in_sta_offset = 15'd0;
        bif.cp_bag_in_ssn = 12'd0;
        bif.cp_bag_in_sta_ba_data = 32'd0;
        for (int a = 0; a < 32768; a++) mem[a] = 32'd0;

        set_hdr(CFG_A, 10'h3CA, 16'hF064, 16'd64, 16'hA0A3);   // window 100..163, bufws 10
        set_entry(CFG_A, 10, 16'h0001);
        set_entry(CFG_A, 12, 16'h0001);
        set_hdr(CFG_B, 10'd0, 16'd4090, 16'd64, 16'd57);       // window wraps 4095->0
        set_entry(CFG_B, 6, 16'h00A3);
        set_hdr(CFG_C, 10'd10, 16'd100, 16'd64, 16'd163);
        for (int i = 0; i < 64; i++) set_entry(CFG_C, i, 16'hFFFF);
        set_hdr(CFG_H, 10'd0, 16'd5, 16'd1, 16'd5);            // single-entry window
        for (int i = 0; i < 64; i++) set_entry(CFG_H, i, 16'h8000);
        set_hdr(CFG_D, 10'd0, 16'd100, 16'd0, 16'd163);        // winsize 0
        set_hdr(CFG_E, 10'd0, 16'd100, 16'd64, 16'd160);       // span mismatch
        set_hdr(CFG_F, 10'd0, 16'd100, 16'd65, 16'd164);       // winsize 65

        test_reset();
        test_windows();
        test_fail();
        test_abort();
        test_back_to_back();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uu_acmac_cp_ba_bitmap_gen.md
# uu_acmac_cp_ba_bitmap_gen

Builds the 64-bit compressed BlockAck bitmap for one BA session: it reads the receive scoreboard that the CP bitmap-update stage keeps in sta_ba_info memory and produces the bitmap that goes into an outgoing BlockAck frame. It sits directly downstream of that stage on the shared sta_ba_info read port and feeds the TX BlockAck frame builder. Each request completes in a fixed number of cycles.

## Interface

Parameters: none. All sizes come from defines.h: 64-entry scoreboard, 12-bit SN space, UU_SUCCESS/UU_FAILURE.

- clk  in  1  clock.
- rst_n  in  1  reset. Synchronous and active-high; the name follows codebase convention only.
- cp_bag_en  in  1  block enable. Low has the same effect as reset.
- cp_bag_in_req  in  1  single-cycle start pulse. Ignored while busy.
- cp_bag_in_sta_offset  in  15  base address of the station's sta_ba_info record.
- cp_bag_in_ssn  in  12  starting sequence number from the BAR or the implicit SSN.
- cp_bag_out_busy  out  1  high from the cycle after an accepted req through the done cycle.
- cp_bag_out_sta_ba_en  out  1  memory read enable. High only in address-issue cycles.
- cp_bag_out_sta_ba_addr  out  15  memory read address.
- cp_bag_in_sta_ba_data  in  32  memory read data, valid 1 cycle after the addr/en cycle.
- cp_bag_out_bitmap  out  64  result; bit j corresponds to SN (ssn+j) mod 4096.
- cp_bag_out_done  out  1  one-cycle pulse; bitmap and res are valid in this cycle.
- cp_bag_out_res  out  32  UU_SUCCESS or UU_FAILURE.
- cp_bag_out_basic_data  out  16  fragment bitmap beat (see Configuration).
- cp_bag_out_basic_val  out  1  beat valid.

## Operation

Memory layout, relative to the offset:
- +33[25:16]: buf_winstart (6 LSBs used).
- +66[31:16]: winstart.
- +67[31:16]: winsize.
- +67[15:0]: winend.
- Scoreboard entry i (0..63) is the 16-bit fragment bitmap at word offset+1+((i+1)>>1). Odd i uses [15:0]; even i uses [31:16].

FSM states: IDLE -> HDR -> CHK -> BMP -> DONE -> IDLE.
- IDLE: on req, latch offset and ssn, clear bitmap, go to HDR.
- HDR: issue reads +33, +66, +67 on three consecutive cycles. Capture each field from the data returned one cycle later. Mask winstart and winend to 12 bits.
- CHK: one cycle.
  - Fail condition: winsize==0, winsize>64, or ((winend-winstart)&0xFFF) != winsize-1. On fail, go to DONE with res=UU_FAILURE and bitmap all 0.
  - Otherwise go to BMP.
- BMP: for j=0..63, issue one read per cycle, back-to-back.
  - sn=(ssn+j)&0xFFF.
  - d=(sn-winstart)&0xFFF.
  - inwin = d <= (winend-winstart)&0xFFF.
  - idx=(buf_winstart+d)&63.
  - Address is the word for idx when inwin. When not inwin, the address is offset+1 and the data is discarded.
  - A pipeline register carries inwin and the half-select to the data cycle.
  - bitmap[j] = inwin && (entry != 0).
- DONE: one cycle. Pulse done and set res=UU_SUCCESS on the non-fail path. bitmap holds its value until the next accepted req.

Arithmetic:
- All SN arithmetic is modulo 4096, so a window spanning 4095->0 is handled with no special case.
- The j counter is 7 bits and terminates at 64.

## Timing

Cycle 0 is the cycle in which req is sampled.
- Header addresses are issued in cycles 1–3; header data arrives in cycles 2–4.
- CHK is cycle 5.
- Bitmap addresses are issued in cycles 6–69; bitmap data arrives in cycles 7–70.
- done is asserted in cycle 71 on success, or cycle 6 on failure.
- busy is high in cycles 1..done.

Reset and enable:
- Reset values: busy=0, sta_ba_en=0, addr=0, bitmap=0, done=0, res=UU_FAILURE, basic_data=0, basic_val=0. FSM is in IDLE.
- rst_n high, or cp_bag_en low, mid-operation: on the next edge, return to IDLE with all outputs at reset values. No done is produced.

Request handling:
- req in the DONE cycle is ignored.
- req in the cycle after DONE is accepted.

## Configuration

- BA_BASIC_BITMAP_EN defined:
  - In each BMP data cycle (cycles 7–70), basic_val=1.
  - basic_data = the entry's 16-bit fragment bitmap if inwin, else 0.
  - This gives 64 beats in j order, for Basic BlockAck frames.
- Undefined: basic_data and basic_val are tied to 0 and the beat logic is not synthesized. The compressed bitmap is unaffected.

## Test plan

- Window 100..163, buf_winstart=10, entries idx 10 and 12 = 0x0001, all others 0; ssn=100 -> done in cycle 71, res=UU_SUCCESS, bitmap=0x5.
- Wrap case: winstart=4090, winend=57, winsize=64, buf_winstart=0, entry idx 6 nonzero; ssn=4090 -> bitmap bit 6 set (SN 0). With ssn=4094, bit 2 set instead.
- ssn=200 with window 100..163 and all entries nonzero -> bitmap=0, res=UU_SUCCESS; addresses in cycles 6–69 still issue.
- winsize=0, or winend-winstart != winsize-1 -> done in cycle 6, res=UU_FAILURE, bitmap=0.
- cp_bag_en dropped in cycle 30 -> busy=0 and sta_ba_en=0 on the next edge, no done. A new req then completes normally at cycle 71.
- With BA_BASIC_BITMAP_EN: exactly 64 basic_val beats in cycles 7–70, and the beat for an in-window entry equals its stored value (e.g. 0x00A3). Without the macro, basic_val stays 0.
